sincro_vga: RTL and testbench

SINCRO_VGA -- requirements
Module: sincro_vga

---
 rtl/sincro_vga.sv | 85 ++++++++
 tb/tb_sincro_vga.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sincro_vga.sv
// rtl/sincro_vga.sv - VGA timing generator: pixel divider, column/line counters, syncs.
// Optional end_frame output when SINCRO_VGA_END_FRAME_EN is defined.
module sincro_vga #(
    parameter int C_CLK_DIV     = 4,
    parameter int C_PXL_TOTAL   = 800,
    parameter int C_PXL_VISIBLE = 640,
    parameter int C_PXL_FPORCH  = 16,
    parameter int C_PXL_SYNC    = 96,
    parameter int C_LIN_TOTAL   = 525,
    parameter int C_LIN_VISIBLE = 480,
    parameter int C_LIN_FPORCH  = 10,
    parameter int C_LIN_SYNC    = 2
) (
    input  logic       rst,
    input  logic       clk,
    output logic       visible,
    output logic [9:0] col,
    output logic [9:0] fila,
    output logic       hsync,
    output logic       vsync,
`ifdef SINCRO_VGA_END_FRAME_EN
    output logic       end_frame,
`endif
    output logic       new_pxl
);

    // Bounds precomputed as 10-bit constants so no comparison widens or wraps.
    localparam logic [3:0] DIV_LAST = 4'(C_CLK_DIV - 1);
    localparam logic [9:0] PXL_LAST = 10'(C_PXL_TOTAL - 1);
    localparam logic [9:0] LIN_LAST = 10'(C_LIN_TOTAL - 1);
    localparam logic [9:0] PXL_VIS  = 10'(C_PXL_VISIBLE);
    localparam logic [9:0] LIN_VIS  = 10'(C_LIN_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(C_PXL_VISIBLE + C_PXL_FPORCH);
    localparam logic [9:0] HS_LAST  = 10'(C_PXL_VISIBLE + C_PXL_FPORCH + C_PXL_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(C_LIN_VISIBLE + C_LIN_FPORCH);
    localparam logic [9:0] VS_LAST  = 10'(C_LIN_VISIBLE + C_LIN_FPORCH + C_LIN_SYNC - 1);

    logic [3:0] div_q, div_d;
    logic [9:0] col_q, col_d;
    logic [9:0] fila_q, fila_d;
    logic       pxl_tick;
    logic       line_end;

    assign pxl_tick = (div_q == DIV_LAST);
    assign line_end = pxl_tick && (col_q == PXL_LAST);

    always_comb begin
        div_d  = div_q;
        col_d  = col_q;
        fila_d = fila_q;
        if (pxl_tick) begin
            div_d = '0;
            col_d = (col_q == PXL_LAST) ? '0 : col_q + 10'd1;
        end else begin
            div_d = div_q + 4'd1;
        end
        if (line_end) begin
            fila_d = (fila_q == LIN_LAST) ? '0 : fila_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            col_q  <= '0;
            fila_q <= '0;
        end else begin
            div_q  <= div_d;
            col_q  <= col_d;
            fila_q <= fila_d;
        end
    end

    assign col     = col_q;
    assign fila    = fila_q;
    assign new_pxl = pxl_tick;
    assign visible = (col_q < PXL_VIS) && (fila_q < LIN_VIS);
    assign hsync   = !((col_q >= HS_FIRST) && (col_q <= HS_LAST));
    assign vsync   = !((fila_q >= VS_FIRST) && (fila_q <= VS_LAST));

`ifdef SINCRO_VGA_END_FRAME_EN
    assign end_frame = line_end && (fila_q == LIN_LAST);
`endif

endmodule

// File: tb/tb_sincro_vga.sv
// tb/tb_sincro_vga.sv - directed bench for sincro_vga: default line timing, 10-line frame.
module tb_sincro_vga;

    localparam int LINE  = 3200;
    localparam int FRAME = 10 * LINE;

    logic       rst;
    logic       clk;
    logic       visible;
    logic [9:0] col;
    logic [9:0] fila;
    logic       hsync;
    logic       vsync;
    logic       new_pxl;
`ifdef SINCRO_VGA_END_FRAME_EN
    logic       end_frame;
`endif

    int n;
    int n_total;
    int n_pass;

    sincro_vga #(
        .C_CLK_DIV    (4),
        .C_PXL_TOTAL  (800),
        .C_PXL_VISIBLE(640),
        .C_PXL_FPORCH (16),
        .C_PXL_SYNC   (96),
        .C_LIN_TOTAL  (10),
        .C_LIN_VISIBLE(6),
        .C_LIN_FPORCH (1),
        .C_LIN_SYNC   (2)
    ) dut (
        .rst      (rst),
        .clk      (clk),
        .visible  (visible),
        .col      (col),
        .fila     (fila),
        .hsync    (hsync),
        .vsync    (vsync),
`ifdef SINCRO_VGA_END_FRAME_EN
        .end_frame(end_frame),
`endif
        .new_pxl  (new_pxl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    endtask

    // n counts rising edges since rst fell; sampling happens on the falling edge.
    task automatic step_to(input int target);
        while (n < target) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        n       = 0;
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_col", 32'(col), 0);
        check("rst_fila", 32'(fila), 0);
        check("rst_visible", 32'(visible), 1);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_new_pxl", 32'(new_pxl), 0);

        rst = 1'b0;
        check("c0_new_pxl", 32'(new_pxl), 0);
        step_to(2);
        check("c2_new_pxl", 32'(new_pxl), 0);
        step_to(3);
        check("c3_new_pxl", 32'(new_pxl), 1);
        check("c3_col", 32'(col), 0);
        step_to(4);
        check("c4_col", 32'(col), 1);
        check("c4_new_pxl", 32'(new_pxl), 0);
        step_to(7);
        check("c7_new_pxl", 32'(new_pxl), 1);
        check("c7_col", 32'(col), 1);
        step_to(8);
        check("c8_col", 32'(col), 2);

        step_to(2559);
        check("col639", 32'(col), 639);
        check("vis_col639", 32'(visible), 1);
        step_to(2560);
        check("vis_col640", 32'(visible), 0);

        step_to(2623);
        check("hs_before", 32'(hsync), 1);
        step_to(2624);
        check("hs_first_col", 32'(col), 656);
        check("hs_first", 32'(hsync), 0);
        step_to(3007);
        check("hs_last_col", 32'(col), 751);
        check("hs_last", 32'(hsync), 0);
        step_to(3008);
        check("hs_after", 32'(hsync), 1);

        step_to(3199);
        check("line_end_col", 32'(col), 799);
        check("line_end_fila", 32'(fila), 0);
        step_to(3200);
        check("line_wrap_col", 32'(col), 0);
        check("line_wrap_fila", 32'(fila), 1);

        step_to(5 * LINE);
        check("vis_fila5", 32'(visible), 1);
        step_to(6 * LINE);
        check("fila6", 32'(fila), 6);
        check("vis_fila6", 32'(visible), 0);

        step_to(7 * LINE - 1);
        check("vs_before", 32'(vsync), 1);
        step_to(7 * LINE);
        check("vs_first", 32'(vsync), 0);
        step_to(7 * LINE + 2624);
        check("vs_mid_hsync", 32'(hsync), 0);
        check("vs_mid", 32'(vsync), 0);
        step_to(9 * LINE - 1);
        check("vs_last_fila", 32'(fila), 8);
        check("vs_last", 32'(vsync), 0);
        step_to(9 * LINE);
        check("vs_after", 32'(vsync), 1);

        step_to(FRAME - 1);
        check("frame_end_fila", 32'(fila), 9);
        check("frame_end_col", 32'(col), 799);
        check("frame_end_new_pxl", 32'(new_pxl), 1);
`ifdef SINCRO_VGA_END_FRAME_EN
        check("end_frame_hi", 32'(end_frame), 1);
`endif
        step_to(FRAME);
        check("frame_wrap_fila", 32'(fila), 0);
        check("frame_wrap_col", 32'(col), 0);
`ifdef SINCRO_VGA_END_FRAME_EN
        check("end_frame_lo", 32'(end_frame), 0);
`endif

        step_to(FRAME + 3 * LINE + 400 * 4 + 1);
        check("pre_rst_fila", 32'(fila), 3);
        check("pre_rst_col", 32'(col), 400);
        rst = 1'b1;
        #1;
        check("async_col", 32'(col), 0);
        check("async_fila", 32'(fila), 0);
        check("async_hsync", 32'(hsync), 1);
        check("async_vsync", 32'(vsync), 1);
        repeat (3) @(negedge clk);
        check("held_col", 32'(col), 0);
        check("held_new_pxl", 32'(new_pxl), 0);

        rst = 1'b0;
        n   = 0;
        step_to(4);
        check("resume_col", 32'(col), 1);
        step_to(FRAME - 2);
        check("new_frame_pre_np", 32'(new_pxl), 0);
`ifdef SINCRO_VGA_END_FRAME_EN
        check("end_frame_pre", 32'(end_frame), 0);
`endif
        step_to(FRAME - 1);
        check("new_frame_end_fila", 32'(fila), 9);
        check("new_frame_end_col", 32'(col), 799);
        step_to(FRAME);
        check("new_frame_wrap_fila", 32'(fila), 0);
        check("new_frame_wrap_col", 32'(col), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
